mlp_bias_act_quant: RTL and testbench

Post-accumulation stage that sits directly downstream of the MLP MAC array. It takes a finished signed accumulator value and performs:
- signed bias add;
- arithmetic right shift with round-half-up;
- optional ReLU;
- saturation to the signed neuron output width.

It is a 3-stage valid/ready pipeline with full backpressure. Its outputs feed the next layer's activation buffer.

---
 rtl/mlp_bias_act_quant.sv | 146 ++++++++++++++
 tb/tb_mlp_bias_act_quant.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_bias_act_quant.sv
`default_nettype none
// ============================================================================
// Module      : mlp_bias_act_quant
// Description : Bias add, round-half-up arithmetic shift, optional ReLU and
//               signed saturation; 3-stage valid/ready pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_bias_act_quant #(
    parameter int ACC_WIDTH   = 32,
    parameter int BIAS_WIDTH  = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACC_WIDTH-1:0]   acc_in,
    input  logic [BIAS_WIDTH-1:0]  bias_in,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic                   sat_sticky,
    input  logic                   clr_sat
);

    localparam int c_shw = $clog2(ACC_WIDTH + 1);
    localparam logic signed [ACC_WIDTH:0] c_res_max =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] c_res_min =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] c_out_max = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] c_out_min = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    logic                          w_adv1, w_adv2, w_adv3;
    logic                          r_v1, r_v2, r_v3;
    logic signed [ACC_WIDTH:0]     r_sum1, r_res2;
    logic [SHIFT_WIDTH-1:0]        r_shift1;
    logic                          r_relu1, r_relu2;
    logic [OUT_WIDTH-1:0]          r_data3;
    logic                          r_sat3, r_sticky;

    logic signed [ACC_WIDTH:0]     w_sum;
    logic [c_shw-1:0]              w_sh;
    logic signed [ACC_WIDTH+1:0]   w_rnd;
    logic signed [ACC_WIDTH:0]     w_res;
    logic [OUT_WIDTH-1:0]          w_data;
    logic                          w_sat;

    // Each stage moves when it is empty or its successor moves, so bubbles collapse.
    assign w_adv3   = !r_v3 | out_ready;
    assign w_adv2   = !r_v2 | w_adv3;
    assign w_adv1   = !r_v1 | w_adv2;
    assign in_ready = w_adv1;

    assign w_sum = $signed({acc_in[ACC_WIDTH-1], acc_in})
                 + $signed({{(ACC_WIDTH + 1 - BIAS_WIDTH){bias_in[BIAS_WIDTH-1]}}, bias_in});

    always_comb begin
        w_sh  = '0;
        w_rnd = '0;
        if (int'(r_shift1) >= ACC_WIDTH) begin
            w_sh = c_shw'(ACC_WIDTH);
        end else begin
            w_sh = c_shw'(r_shift1);
        end
        if (w_sh != '0) begin
            w_rnd[w_sh - 1'b1] = 1'b1;
        end
        // After a shift of at least one the extra headroom bit is redundant.
        w_res = (ACC_WIDTH + 1)'(($signed({r_sum1[ACC_WIDTH], r_sum1}) + w_rnd) >>> w_sh);
    end

    always_comb begin
        w_data = r_res2[OUT_WIDTH-1:0];
        w_sat  = 1'b0;
        if (r_relu2 && r_res2[ACC_WIDTH]) begin
            w_data = '0;
        end else if (r_res2 > c_res_max) begin
            w_data = c_out_max;
            w_sat  = 1'b1;
        end else if (r_res2 < c_res_min) begin
            w_data = c_out_min;
            w_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_sum1   <= '0;
            r_shift1 <= '0;
            r_relu1  <= 1'b0;
            r_res2   <= '0;
            r_relu2  <= 1'b0;
            r_data3  <= '0;
            r_sat3   <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_sum1   <= w_sum;
                    r_shift1 <= shift;
                    r_relu1  <= relu_en;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_res2  <= w_res;
                    r_relu2 <= r_relu1;
                end
            end
            if (w_adv3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_data3 <= w_data;
                    r_sat3  <= w_sat;
                end
            end
        end
    end

    // A saturated transfer takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (r_v3 && out_ready && r_sat3) begin
            r_sticky <= 1'b1;
        end else if (clr_sat) begin
            r_sticky <= 1'b0;
        end
    end

    assign out_valid  = r_v3;
    assign out_data   = r_data3;
    assign out_sat    = r_sat3;
    assign sat_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_mlp_bias_act_quant.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_bias_act_quant
// Description : Directed self-checking bench for mlp_bias_act_quant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_bias_act_quant;

    localparam int ACC_WIDTH   = 32;
    localparam int BIAS_WIDTH  = 16;
    localparam int OUT_WIDTH   = 8;
    localparam int SHIFT_WIDTH = 6;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [ACC_WIDTH-1:0]   acc_in;
    logic [BIAS_WIDTH-1:0]  bias_in;
    logic [SHIFT_WIDTH-1:0] shift;
    logic                   relu_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_WIDTH-1:0]   out_data;
    logic                   out_sat;
    logic                   sat_sticky;
    logic                   clr_sat;

    int n_checks = 0;
    int n_pass   = 0;

    mlp_bias_act_quant #(
        .ACC_WIDTH  (ACC_WIDTH),
        .BIAS_WIDTH (BIAS_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_in    (acc_in),
        .bias_in   (bias_in),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_sticky(sat_sticky),
        .clr_sat   (clr_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)",
                     tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sdata();
        return 32'($signed(out_data));
    endfunction

    // Sends one sample into an empty pipeline; returns with out_valid seen, not yet consumed.
    task automatic run_sample(input string tag, input logic [31:0] acc, input logic [31:0] bias,
                              input int sh, input logic relu,
                              input logic [31:0] exp_d, input logic exp_s);
        int lat;
        acc_in   = acc;
        bias_in  = bias[BIAS_WIDTH-1:0];
        shift    = sh[SHIFT_WIDTH-1:0];
        relu_en  = relu;
        in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        acc_in   = 'x;
        bias_in  = 'x;
        shift    = 'x;
        relu_en  = 1'bx;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_data"}, sdata(), exp_d);
        check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0]  pat;
        int          n_in, n_out;
        logic        hold_pending;
        logic [31:0] hold_val;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        acc_in    = '0;
        bias_in   = '0;
        shift     = '0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        clr_sat   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", sdata(), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_sticky", 32'(sat_sticky), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Basic and rounding
        run_sample("basic", 32'd1000, 32'd24, 4, 1'b0, 32'd64, 1'b0);  tick();
        run_sample("rnd_23", 32'd23, 32'd0, 4, 1'b0, 32'd1, 1'b0);     tick();
        run_sample("rnd_24", 32'd24, 32'd0, 4, 1'b0, 32'd2, 1'b0);     tick();
        run_sample("rnd_m24", -32'sd24, 32'd0, 4, 1'b0, -32'sd1, 1'b0); tick();
        run_sample("rnd_m25", -32'sd25, 32'd0, 4, 1'b0, -32'sd2, 1'b0); tick();
        run_sample("sh0", 32'd5, 32'd0, 0, 1'b0, 32'd5, 1'b0);         tick();

        // ReLU, saturation and the sticky flag
        run_sample("relu_neg", -32'sd300, 32'd0, 0, 1'b1, 32'd0, 1'b0); tick();
        check("sticky_after_relu", 32'(sat_sticky), 32'd0);
        run_sample("sat_neg", -32'sd300, 32'd0, 0, 1'b0, -32'sd128, 1'b1); tick();
        check("sticky_set", 32'(sat_sticky), 32'd1);
        run_sample("sat_pos", 32'd300, 32'd0, 0, 1'b0, 32'd127, 1'b1); tick();
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        check("sticky_clr", 32'(sat_sticky), 32'd0);
        run_sample("sat_pos2", 32'd300, 32'd0, 0, 1'b0, 32'd127, 1'b1);
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        check("sticky_set_wins", 32'(sat_sticky), 32'd1);

        // Wide overflow and over-range shift
        run_sample("wide_pos", 32'h7FFF_FFFF, 32'd32767, 0, 1'b0, 32'd127, 1'b1); tick();
        run_sample("wide_neg", 32'h8000_0000, -32'sd32768, 0, 1'b0, -32'sd128, 1'b1); tick();
        run_sample("sh63", 32'd1000, 32'd0, 63, 1'b0, 32'd0, 1'b0); tick();

        // Backpressure stream 1..8
        pat          = 7'b1101001;
        n_in         = 0;
        n_out        = 0;
        hold_pending = 1'b0;
        hold_val     = '0;
        bias_in      = '0;
        shift        = '0;
        relu_en      = 1'b0;
        for (int c = 0; c < 60 && n_out < 8; c++) begin
            out_ready = pat[c % 7];
            in_valid  = (n_in < 8);
            acc_in    = 32'(n_in + 1);
            #1;
            if (hold_pending) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_data", sdata(), hold_val);
            end
            check("bp_in_ready", 32'(in_ready), 32'(!((n_in - n_out) == 3 && !out_ready)));
            if (out_valid && out_ready) begin
                check("bp_order", sdata(), 32'(n_out + 1));
                n_out++;
            end
            hold_pending = out_valid && !out_ready;
            hold_val     = sdata();
            if (in_valid && in_ready) n_in++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 32'(n_out), 32'd8);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset mid-stream with a full pipeline and sticky set
        run_sample("pre_rst", 32'd300, 32'd0, 0, 1'b0, 32'd127, 1'b1); tick();
        check("pre_rst_sticky", 32'(sat_sticky), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            acc_in   = 32'(10 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_head", sdata(), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", sdata(), 32'd0);
        check("mid_rst_sticky", 32'(sat_sticky), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        run_sample("post_rst", 32'd40, 32'd0, 2, 1'b0, 32'd10, 1'b0);
        tick();
        check("post_rst_no_stale", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
